// File: rtl/npu_defs.sv
// Shared NPU widths, FSM encoding, beat control struct and saturation limits.
package npu_defs;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH   = 2*DEF_DATA_WIDTH + 4;
  localparam int DEF_ACC_WIDTH   = DEF_OUT_WIDTH + 8;
  localparam int DEF_SHIFT_WIDTH = 6;

  localparam int SAT_MAX = 2**(DEF_DATA_WIDTH-1) - 1;
  localparam int SAT_MIN = -(2**(DEF_DATA_WIDTH-1));

  typedef enum logic {ACC = 1'b0, DRAIN = 1'b1} state_t;

  typedef struct packed {
    logic first;
    logic last;
  } beat_ctl_t;
endpackage

// File: rtl/requant_lane.sv
// One lane of round / arithmetic shift / optional ReLU / signed saturate.
// PSUM_ACCUMULATOR_RELU_EN clamps negative lanes to zero before saturation.
module requant_lane
  import npu_defs::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic [DATA_WIDTH-1:0]  res
);
  // One guard bit keeps the rounding add from overflowing.
  localparam int EW = ACC_WIDTH + 1;

  logic signed [EW-1:0] ext, rnd, shf, hi, lo;

  assign hi = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  assign lo = {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    ext = {acc[ACC_WIDTH-1], acc};
    rnd = ext;
    if (32'(shift) >= ACC_WIDTH) begin
      shf = {EW{acc[ACC_WIDTH-1]}};
    end else begin
      if (shift != '0) rnd = ext + (EW'(1) << (shift - SHIFT_WIDTH'(1)));
      shf = rnd >>> shift;
    end
`ifdef PSUM_ACCUMULATOR_RELU_EN
    if (shf[EW-1]) shf = '0;
`endif
    res = shf[DATA_WIDTH-1:0];
    if (shf > hi)      res = hi[DATA_WIDTH-1:0];
    else if (shf < lo) res = lo[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/psum_accumulator.sv
// K-tile partial-sum accumulator with per-lane requant and a valid/ready result port.
// Build with PSUM_ACCUMULATOR_RELU_EN to clamp negative results to zero.
module psum_accumulator
  import npu_defs::*;
#(
  parameter int ROW_WIDTH   = 10,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
  parameter int MAX_TILES   = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_first,
  input  logic                            in_last,
  input  logic [ROW_WIDTH*OUT_WIDTH-1:0]  in_data,
  input  logic [SHIFT_WIDTH-1:0]          shift,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ROW_WIDTH*DATA_WIDTH-1:0] out_data,
  output logic [7:0]                      tile_cnt,
  output logic                            err_tiles
);
  localparam logic [7:0] MAX_T = 8'(MAX_TILES);

  state_t    state, state_nxt;
  beat_ctl_t ctl;
  logic      accept, hs, empty;
  logic [ROW_WIDTH-1:0][ACC_WIDTH-1:0]  acc, acc_nxt;
  logic [ROW_WIDTH-1:0][DATA_WIDTH-1:0] rq;

  assign ctl    = '{first: in_first, last: in_last};
  assign accept = in_valid & in_ready;
  assign hs     = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && ctl.last) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  for (genvar i = 0; i < ROW_WIDTH; i++) begin : g_lane
    logic [OUT_WIDTH-1:0] lane_in;
    assign lane_in    = in_data[OUT_WIDTH*(i+1)-1 -: OUT_WIDTH];
    assign acc_nxt[i] = ((ctl.first || empty) ? '0 : acc[i])
                      + {{(ACC_WIDTH-OUT_WIDTH){lane_in[OUT_WIDTH-1]}}, lane_in};
    requant_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_rq (
      .acc  (acc_nxt[i]),
      .shift(shift),
      .res  (rq[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      out_data  <= '0;
      tile_cnt  <= '0;
      err_tiles <= 1'b0;
      empty     <= 1'b1;
    end else if (hs) begin
      acc      <= '0;
      tile_cnt <= '0;
      empty    <= 1'b1;
    end else if (accept) begin
      acc   <= acc_nxt;
      empty <= 1'b0;
      if (ctl.last) out_data <= rq;
      if (ctl.first)             tile_cnt <= 8'd1;
      else if (tile_cnt != 8'hFF) tile_cnt <= tile_cnt + 8'd1;
      // Overflowing the group limit and continuing a group that never started are both sticky.
      if (!ctl.first && (empty || tile_cnt >= MAX_T)) err_tiles <= 1'b1;
    end
  end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the column adder-tree array. Consumes ROW_WIDTH signed column sums per beat.
- Accumulates sums across K-dimension tiles, marked by first/last beats.
- On the last tile, rounds, right-shifts and saturates each lane to DATA_WIDTH.
- Presents one output vector per tile group on a valid/ready handshake to the output buffer.

Parameters:
- ROW_WIDTH, 10, number of lanes (column sums per beat)
- DATA_WIDTH, 16, output element width (signed)
- OUT_WIDTH, 36, input column-sum width (signed, = 2*DATA_WIDTH+4)
- ACC_WIDTH, 44, accumulator width per lane (OUT_WIDTH+8, supports 256 tiles without wrap)
- SHIFT_WIDTH, 6, width of requant shift amount
- MAX_TILES, 255, beat-count limit per group

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  column-sum beat valid; the controller aligns it to the adder-tree latency
- in_ready  out  1  block accepts beat
- in_first  in  1  first tile of group; discards prior accumulator contents
- in_last  in  1  last tile of group; triggers requant/output
- in_data  in  ROW_WIDTH*OUT_WIDTH  packed signed sums, lane i at [OUT_WIDTH*(i+1)-1 -: OUT_WIDTH]
- shift  in  SHIFT_WIDTH  right-shift amount, sampled on the accepted last beat
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts result
- out_data  out  ROW_WIDTH*DATA_WIDTH  packed signed results, same lane order
- tile_cnt  out  8  beats accumulated in current/last group
- err_tiles  out  1  sticky: a group exceeded MAX_TILES beats, or a beat arrived without in_first on an empty accumulator

Behaviour:
- Reset (async, active-high): state=ACC, all accumulators 0, out_valid=0, out_data=0, tile_cnt=0, err_tiles=0, empty flag=1.
- States:
  - ACC: in_ready=1.
  - DRAIN: in_ready=0, out_valid=1.
- Accept is in_valid&in_ready. Per lane: next = (in_first ? 0 : acc) + sign_extend(in_data lane). ACC_WIDTH arithmetic wraps in two's complement; no saturation inside the accumulator.
- tile_cnt: set to 1 on in_first, otherwise increments, saturating at 255. Cleared on output handshake.
- err_tiles is set when either:
  - an accepted beat would make tile_cnt exceed MAX_TILES; or
  - a beat without in_first is accepted while empty=1 (empty is set after reset and after each output handshake).
  - In the second case the beat is still accumulated onto zero.
- Accepted beat with in_last: next cycle state=DRAIN, out_valid=1, out_data=requant(next), where requant per lane is:
  - round: if shift>0, add 1<<(shift-1)
  - arithmetic right shift by shift
  - saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]
- Latency: 1 cycle from the last beat to out_valid.
- in_first and in_last on the same beat form a single-tile group.
- DRAIN: out_data/out_valid held stable until out_ready. On handshake: state=ACC, accumulators cleared, empty=1. Next beat accepted no earlier than the following cycle.
- in_valid during DRAIN is ignored (in_ready=0); the upstream holds the beat.
- shift >= ACC_WIDTH: result is 0 for non-negative lanes and -1 for negative lanes (full sign shift; rounding add skipped).
- Reset mid-group or mid-DRAIN: partial sums and the pending output are discarded immediately.

Optional Feature:
- Macro: PSUM_ACCUMULATOR_RELU_EN.
- Defined: after shift and before saturation, negative lanes are forced to 0. Output range is [0, 2^(DATA_WIDTH-1)-1].
- Undefined: signed saturation only. Port list is identical either way.

Decomposition:
- Shared package/include npu_defs holds:
  - DATA_WIDTH, OUT_WIDTH, ACC_WIDTH, SHIFT_WIDTH defaults
  - state encodings ACC=1'b0, DRAIN=1'b1
  - saturation limit constants
- Sub-module requant_lane (combinational round/shift/ReLU/saturate for one lane), instantiated ROW_WIDTH times via generate.

Test Plan:
- Single tile: first=last=1, all lanes 100, shift=2 -> out_valid next cycle, every lane 25, tile_cnt=1.
- Three tiles with lane0 = 1000, -300, 50 and shift=0 -> lane0=750. Beats 1-2 produce no output; tile_cnt=3.
- Saturation: lane=2^20, shift=0 -> 32767. Lane=-2^20 -> -32768, or 0 with PSUM_ACCUMULATOR_RELU_EN.
- Rounding: lane=5, shift=1 -> 3; lane=-5, shift=1 -> -2; shift=50 on -5 -> -1.
- Backpressure: hold out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0 and out_data stable throughout. Handshake, then the next beat is accepted and out_data is unaffected.
- Errors and reset:
  - beat without in_first after reset -> err_tiles=1 (sticky)
  - assert reset during DRAIN -> out_valid=0 immediately, accumulators 0
